// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter: round-robin time-sharing of the six HEX digits among
// NREQ message sources. Each grant captures one 42-bit active-low pattern and
// holds it on the display for HOLD cycles, then pulses done and re-arbitrates.
// The last pattern stays on the digits while idle. All outputs are registered.

module hex_display_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned HOLD = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [42*NREQ-1:0]     msg_in,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic                   busy,
  output logic [6:0]             HEX0,
  output logic [6:0]             HEX1,
  output logic [6:0]             HEX2,
  output logic [6:0]             HEX3,
  output logic [6:0]             HEX4,
  output logic [6:0]             HEX5
);

  localparam int unsigned MSG_W = 42;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

  typedef enum logic {
    IDLE,
    SHOW
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   last;
  logic [CNT_W-1:0]   cnt;
  logic               armed;

  logic               pick_valid;
  logic [PTR_W-1:0]   pick_idx;
  logic [MSG_W-1:0]   msg_arr [NREQ];
  logic [MSG_W-1:0]   pick_msg;

  // Split the flat message bus into one pattern per requester.
  for (genvar gi = 0; gi < int'(NREQ); gi++) begin : g_msg
    assign msg_arr[gi] = msg_in[gi*MSG_W +: MSG_W];
  end

  // Round-robin search: first set request after the last winner, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      if (!pick_valid && req[PTR_W'((int'(last) + k) % int'(NREQ))]) begin
        pick_valid = 1'b1;
        pick_idx   = PTR_W'((int'(last) + k) % int'(NREQ));
      end
    end
  end

  assign pick_msg = msg_arr[pick_idx];

  // Grant/hold FSM with registered display, grant, done and busy outputs.
  // armed blocks arbitration on the first edge after reset release so the
  // earliest grant lands on the second edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= PTR_W'(NREQ - 1);
      cnt   <= '0;
      armed <= 1'b0;
      gnt   <= '0;
      done  <= '0;
      busy  <= 1'b0;
      HEX0  <= 7'h7F;
      HEX1  <= 7'h7F;
      HEX2  <= 7'h7F;
      HEX3  <= 7'h7F;
      HEX4  <= 7'h7F;
      HEX5  <= 7'h7F;
    end else begin
      armed <= 1'b1;
      gnt   <= '0;
      done  <= '0;
      case (state)
        IDLE: begin
          if (armed && pick_valid) begin
            state <= SHOW;
            last  <= pick_idx;
            cnt   <= CNT_W'(HOLD - 1);
            gnt   <= NREQ'(1) << pick_idx;
            busy  <= 1'b1;
            HEX0  <= pick_msg[0*SEG_W +: SEG_W];
            HEX1  <= pick_msg[1*SEG_W +: SEG_W];
            HEX2  <= pick_msg[2*SEG_W +: SEG_W];
            HEX3  <= pick_msg[3*SEG_W +: SEG_W];
            HEX4  <= pick_msg[4*SEG_W +: SEG_W];
            HEX5  <= pick_msg[5*SEG_W +: SEG_W];
          end
        end
        SHOW: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= NREQ'(1) << last;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Self-checking bench for hex_display_arbiter (NREQ=3, HOLD=4): directed
// table, hand-written corner sequences and random traffic against a
// timeline-based reference model.

module tb_hex_display_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned HOLD = 4;
  localparam logic [41:0] BLANK = {6{7'h7F}};

  logic           clk = 1'b0;
  logic           rst;
  logic [2:0]     req;
  logic [125:0]   msg_in;
  logic [2:0]     gnt;
  logic [2:0]     done;
  logic           busy;
  logic [6:0]     HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [41:0]    hex_all;

  int checks   = 0;
  int failures = 0;

  hex_display_arbiter #(.NREQ(NREQ), .HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .msg_in(msg_in),
    .gnt(gnt), .done(done), .busy(busy),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2),
    .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );

  assign hex_all = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  always #5 clk = ~clk;

  // Reference model: a grant at edge ending cycle c shows cycles c+1..c+HOLD
  // and done appears in cycle c+HOLD+1.
  bit          m_show;
  bit          m_armed;
  int          m_owner;
  int          m_end;
  int          m_last;
  int          cyc;
  logic [41:0] m_hex;
  logic [2:0]  m_gnt;
  logic [2:0]  m_done;
  logic        m_busy;

  function automatic void model_reset();
    m_show  = 1'b0;
    m_armed = 1'b0;
    m_last  = int'(NREQ) - 1;
    m_owner = 0;
    m_end   = 0;
    m_hex   = BLANK;
    m_gnt   = 3'b000;
    m_done  = 3'b000;
    m_busy  = 1'b0;
  endfunction

  function automatic void model_edge(input logic r, input logic [2:0] rq,
                                     input logic [125:0] mg);
    bit found;
    if (r) begin
      model_reset();
    end else begin
      m_gnt  = 3'b000;
      m_done = 3'b000;
      if (!m_armed) begin
        m_armed = 1'b1;
      end else if (m_show) begin
        if (cyc == m_end) begin
          m_done = 3'(1 << m_owner);
          m_show = 1'b0;
          m_busy = 1'b0;
        end
      end else if (rq != 3'b000) begin
        found = 1'b0;
        for (int k = 1; k <= int'(NREQ); k++) begin
          int idx;
          idx = (m_last + k) % int'(NREQ);
          if (!found && rq[idx] == 1'b1) begin
            found   = 1'b1;
            m_owner = idx;
          end
        end
        m_gnt  = 3'(1 << m_owner);
        m_hex  = mg[m_owner*42 +: 42];
        m_last = m_owner;
        m_show = 1'b1;
        m_busy = 1'b1;
        m_end  = cyc + int'(HOLD);
      end
    end
    cyc++;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("gnt",  64'(gnt),     64'(m_gnt));
    chk("done", 64'(done),    64'(m_done));
    chk("busy", 64'(busy),    64'(m_busy));
    chk("hex",  64'(hex_all), 64'(m_hex));
  endtask

  // One clock: sample inputs, advance model at the edge, compare 1 ns later.
  task automatic step();
    logic         r;
    logic [2:0]   rq;
    logic [125:0] mg;
    r  = rst;
    rq = req;
    mg = msg_in;
    @(posedge clk);
    model_edge(r, rq, mg);
    #1;
    cmp_model();
  endtask

  task automatic wait_gnt(input int maxc, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      step();
      if (gnt != 3'b000) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, 64'(ok), 64'(1));
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic        busy;
    logic [41:0] hex;
  } vec_t;

  vec_t        tbl [7];
  logic [41:0] pat0;
  logic [41:0] saved_hex;
  int          gq [$];
  int          tq [$];
  int          exp_g [4];
  int          exp_t [4];
  int          gnt1_seen;

  initial begin
    pat0 = {{5{7'h7F}}, 7'h40};
    tbl[0] = '{req: 3'b001, gnt: 3'b001, done: 3'b000, busy: 1'b1, hex: pat0};
    tbl[1] = '{req: 3'b000, gnt: 3'b000, done: 3'b000, busy: 1'b1, hex: pat0};
    tbl[2] = '{req: 3'b000, gnt: 3'b000, done: 3'b000, busy: 1'b1, hex: pat0};
    tbl[3] = '{req: 3'b000, gnt: 3'b000, done: 3'b000, busy: 1'b1, hex: pat0};
    tbl[4] = '{req: 3'b000, gnt: 3'b000, done: 3'b001, busy: 1'b0, hex: pat0};
    tbl[5] = '{req: 3'b000, gnt: 3'b000, done: 3'b000, busy: 1'b0, hex: pat0};
    tbl[6] = '{req: 3'b000, gnt: 3'b000, done: 3'b000, busy: 1'b0, hex: pat0};
    exp_g = '{1, 2, 4, 1};
    exp_t = '{1, 6, 11, 16};

    // Reset with all requests high.
    cyc = 0;
    model_reset();
    rst = 1'b1;
    req = 3'b111;
    msg_in = '0;
    msg_in[41:0]   = pat0;
    msg_in[83:42]  = 42'h1_2345_6789_A;
    msg_in[125:84] = 42'h2_BCDE_F012_3;
    #3;
    chk("rst_hex",  64'(hex_all), 64'(BLANK));
    chk("rst_gnt",  64'(gnt),     64'(0));
    chk("rst_done", 64'(done),    64'(0));
    chk("rst_busy", 64'(busy),    64'(0));
    step();
    step();
    rst = 1'b0;
    step();
    chk("armed_no_gnt", 64'(gnt), 64'(0));
    step();
    chk("first_gnt", 64'(gnt), 64'(3'b001));
    req = 3'b000;
    repeat (6) step();

    // Single request table.
    for (int i = 0; i < 7; i++) begin
      req = tbl[i].req;
      step();
      chk("tbl_gnt",  64'(gnt),     64'(tbl[i].gnt));
      chk("tbl_done", 64'(done),    64'(tbl[i].done));
      chk("tbl_busy", 64'(busy),    64'(tbl[i].busy));
      chk("tbl_hex",  64'(hex_all), 64'(tbl[i].hex));
    end

    // Round-robin fairness from a fresh reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 3'b111;
    for (int n = 1; n <= 17; n++) begin
      step();
      if (gnt != 3'b000) begin
        gq.push_back(int'(gnt));
        tq.push_back(n - 1);
      end
    end
    chk("rr_count", 64'(gq.size()), 64'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < gq.size()) begin
        chk("rr_gnt",   64'(gq[i]), 64'(exp_g[i]));
        chk("rr_cycle", 64'(tq[i]), 64'(exp_t[i]));
      end
    end
    req = 3'b000;
    repeat (6) step();

    // Pointer order: after requester 0, requester 2 wins over 0.
    req = 3'b101;
    wait_gnt(4, "ptr_wait2");
    chk("ptr_first", 64'(gnt), 64'(3'b100));
    req = 3'b001;
    wait_gnt(8, "ptr_wait0");
    chk("ptr_second", 64'(gnt), 64'(3'b001));

    // Message and request changes during SHOW are ignored.
    saved_hex = hex_all;
    req = 3'b000;
    step();
    msg_in[41:0] = ~pat0;
    req = 3'b010;
    gnt1_seen = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (gnt[1]) gnt1_seen++;
    end
    req = 3'b000;
    chk("show_hex_held", 64'(hex_all), 64'(saved_hex));
    for (int i = 0; i < 8; i++) begin
      step();
      if (gnt[1]) gnt1_seen++;
    end
    chk("no_gnt1", 64'(gnt1_seen), 64'(0));
    chk("sticky_hex", 64'(hex_all), 64'(saved_hex));

    // Asynchronous reset in the middle of SHOW.
    req = 3'b010;
    wait_gnt(4, "ar_wait");
    chk("ar_gnt", 64'(gnt), 64'(3'b010));
    req = 3'b000;
    step();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("ar_hex",  64'(hex_all), 64'(BLANK));
    chk("ar_busy", 64'(busy),    64'(0));
    chk("ar_gnt0", 64'(gnt),     64'(0));
    chk("ar_done", 64'(done),    64'(0));
    step();
    rst = 1'b0;
    req = 3'b111;
    step();
    step();
    chk("ar_next_gnt", 64'(gnt), 64'(3'b001));
    req = 3'b000;
    repeat (6) step();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      req = 3'($urandom_range(0, 7));
      msg_in = {$urandom, $urandom, $urandom, $urandom};
      rst = ($urandom_range(0, 149) == 0);
      step();
      chk("gnt_done_overlap", 64'(gnt & done), 64'(0));
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
